// File: rtl/cheby_fir_pkg.sv
// cheby_fir_pkg: shared helpers for the time-multiplexed Chebyshev FIR.
// Provides clog2, the FSM encoding, the accumulator width and the rounding/unity constants.
package cheby_fir_pkg;

    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MAC   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4
    } fir_state_t;

    // Enough headroom that N full-scale products never overflow.
    function automatic int acc_width(input int dw, input int cw, input int n);
        return dw + cw + clog2(n);
    endfunction

    // Half an output LSB, added before the arithmetic right shift.
    function automatic longint round_half(input int frac);
        return (frac > 0) ? (64'sd1 <<< (frac - 1)) : 64'sd0;
    endfunction

    // Unity gain coefficient 2^frac, clipped to the largest positive CW-bit value.
    function automatic longint coef_one(input int frac, input int cw);
        return (frac >= cw - 1) ? ((64'sd1 <<< (cw - 1)) - 64'sd1)
                                : (64'sd1 <<< frac);
    endfunction

endpackage

// File: rtl/cheby_fir_tdm_mac.sv
// cheby_mac_unit: two-stage MAC (registered product, then accumulate) with round/saturate output.
// Ports: in_* issue one tap per cycle; res_* present the finished channel result for one cycle.
module cheby_mac_unit
    import cheby_fir_pkg::*;
#(
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int ACCW = 35,
    parameter int FRAC = 15,
    parameter int CHW  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_clr,
    input  logic                 in_last,
    input  logic [CHW-1:0]       in_ch,
    input  logic signed [DW-1:0] x,
    input  logic signed [CW-1:0] h,
    output logic                 res_valid,
    output logic [CHW-1:0]       res_ch,
    output logic signed [DW-1:0] res_y,
    output logic                 res_sat
);

    localparam int PW = DW + CW;
    localparam int SW = ACCW + 1;
    localparam logic signed [SW-1:0] RND  = SW'(round_half(FRAC));
    localparam logic signed [SW-1:0] MAXV = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic [PW-1:0]          xe;
    logic [PW-1:0]          he;
    logic signed [PW-1:0]   prod_q;
    logic                   p_valid;
    logic                   p_clr;
    logic                   p_last;
    logic [CHW-1:0]         p_ch;
    logic signed [ACCW-1:0] prod_ext;
    logic signed [ACCW-1:0] acc_q;
    logic signed [SW-1:0]   sum;
    logic signed [SW-1:0]   shr;

    // Low PW bits of the product of sign-extended operands equal the signed product.
    always_comb begin
        xe       = {{CW{x[DW-1]}}, x};
        he       = {{DW{h[CW-1]}}, h};
        prod_ext = {{(ACCW-PW){prod_q[PW-1]}}, prod_q};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q    <= '0;
            p_valid   <= 1'b0;
            p_clr     <= 1'b0;
            p_last    <= 1'b0;
            p_ch      <= '0;
            acc_q     <= '0;
            res_valid <= 1'b0;
            res_ch    <= '0;
        end else begin
            p_valid   <= in_valid;
            p_clr     <= in_clr;
            p_last    <= in_last;
            p_ch      <= in_ch;
            if (in_valid) begin
                prod_q <= xe * he;
            end
            if (p_valid) begin
                acc_q <= p_clr ? prod_ext : acc_q + prod_ext;
            end
            res_valid <= p_valid & p_last;
            res_ch    <= p_ch;
        end
    end

    always_comb begin
        sum     = {acc_q[ACCW-1], acc_q} + RND;
        shr     = sum >>> FRAC;
        res_sat = 1'b0;
        res_y   = shr[DW-1:0];
        if (shr > MAXV) begin
            res_y   = MAXV[DW-1:0];
            res_sat = 1'b1;
        end else if (shr < MINV) begin
            res_y   = MINV[DW-1:0];
            res_sat = 1'b1;
        end
    end

endmodule

// File: rtl/cheby_fir_tdm.sv
// cheby_fir_tdm: N-tap, NCH-channel FIR sharing one MAC; donext starts a sample, yvalid ends it.
// Ports: xin/coef_* in, yout/xin_d/sat/yvalid out, busy/overrun status; async active-low rst.
module cheby_fir_tdm
    import cheby_fir_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int DW   = 16,
    parameter  int CW   = 16,
    parameter  int NCH  = 2,
    parameter  int FRAC = 15,
    localparam int AW   = clog2(N),
    localparam int CHW  = clog2(NCH),
    localparam int ACCW = acc_width(DW, CW, N)
) (
    input  logic                clk30x,
    input  logic                rst,
    input  logic                donext,
    input  logic [NCH*DW-1:0]   xin,
    input  logic                coef_we,
    input  logic [AW-1:0]       coef_addr,
    input  logic [CW-1:0]       coef_data,
    output logic                busy,
    output logic                yvalid,
    output logic [NCH*DW-1:0]   yout,
    output logic [NCH*DW-1:0]   xin_d,
    output logic [NCH-1:0]      sat,
    output logic                overrun
);

    localparam logic [AW:0]    N_EXT    = (AW+1)'(N);
    localparam logic [AW-1:0]  TAP_LAST = AW'(N - 1);
    localparam logic [CHW-1:0] CH_LAST  = CHW'(NCH - 1);
    localparam logic [CW-1:0]  H_ONE    = CW'(coef_one(FRAC, CW));

    fir_state_t           state;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        tap_cnt;
    logic [CHW-1:0]       ch_cnt;
    logic                 drain_cnt;
    logic [AW-1:0]        rd_idx;
    logic [AW-1:0]        old_idx;
    logic signed [DW-1:0] x_mem [NCH][N];
    logic signed [CW-1:0] h_reg [N];
    logic signed [DW-1:0] res_y [NCH];
    logic [NCH-1:0]       res_sat;

    logic                 mac_issue;
    logic                 mac_valid;
    logic [CHW-1:0]       mac_ch;
    logic signed [DW-1:0] mac_y;
    logic                 mac_sat;

    // x[n-k] lives k slots behind the newest write, wrapping mod N.
    always_comb begin
        if (wr_ptr >= tap_cnt) begin
            rd_idx = wr_ptr - tap_cnt;
        end else begin
            rd_idx = AW'(({1'b0, wr_ptr} + N_EXT) - {1'b0, tap_cnt});
        end
        old_idx   = (wr_ptr == TAP_LAST) ? '0 : wr_ptr + AW'(1);
        mac_issue = (state == ST_MAC);
    end

    cheby_mac_unit #(
        .DW   (DW),
        .CW   (CW),
        .ACCW (ACCW),
        .FRAC (FRAC),
        .CHW  (CHW)
    ) u_mac (
        .clk       (clk30x),
        .rst       (rst),
        .in_valid  (mac_issue),
        .in_clr    (tap_cnt == '0),
        .in_last   (tap_cnt == TAP_LAST),
        .in_ch     (ch_cnt),
        .x         (x_mem[ch_cnt][rd_idx]),
        .h         (h_reg[tap_cnt]),
        .res_valid (mac_valid),
        .res_ch    (mac_ch),
        .res_y     (mac_y),
        .res_sat   (mac_sat)
    );

    always_ff @(posedge clk30x or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            yvalid    <= 1'b0;
            overrun   <= 1'b0;
            yout      <= '0;
            xin_d     <= '0;
            sat       <= '0;
            wr_ptr    <= '0;
            tap_cnt   <= '0;
            ch_cnt    <= '0;
            drain_cnt <= 1'b0;
            res_sat   <= '0;
            for (int c = 0; c < NCH; c++) begin
                res_y[c] <= '0;
                for (int k = 0; k < N; k++) begin
                    x_mem[c][k] <= '0;
                end
            end
            for (int k = 0; k < N; k++) begin
                h_reg[k] <= (k == 0) ? H_ONE : '0;
            end
        end else begin
            yvalid <= 1'b0;
            if (donext && state != ST_IDLE) begin
                overrun <= 1'b1;
            end
            // Per-channel results arrive during the MAC/DRAIN phases; stage them for OUT.
            if (mac_valid) begin
                res_y[mac_ch]   <= mac_y;
                res_sat[mac_ch] <= mac_sat;
            end
            unique case (state)
                ST_IDLE: begin
                    if (coef_we && ({1'b0, coef_addr} < N_EXT)) begin
                        h_reg[coef_addr] <= coef_data;
                    end
                    if (donext) begin
                        for (int c = 0; c < NCH; c++) begin
                            x_mem[c][wr_ptr] <= xin[c*DW +: DW];
                        end
                        busy  <= 1'b1;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tap_cnt <= '0;
                    ch_cnt  <= '0;
                    state   <= ST_MAC;
                end
                ST_MAC: begin
                    if (tap_cnt == TAP_LAST) begin
                        tap_cnt <= '0;
                        if (ch_cnt == CH_LAST) begin
                            ch_cnt    <= '0;
                            drain_cnt <= 1'b0;
                            state     <= ST_DRAIN;
                        end else begin
                            ch_cnt <= ch_cnt + CHW'(1);
                        end
                    end else begin
                        tap_cnt <= tap_cnt + AW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt) begin
                        state <= ST_OUT;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                ST_OUT: begin
                    for (int c = 0; c < NCH; c++) begin
                        yout[c*DW +: DW]  <= res_y[c];
                        xin_d[c*DW +: DW] <= x_mem[c][old_idx];
                    end
                    sat    <= res_sat;
                    yvalid <= 1'b1;
                    busy   <= 1'b0;
                    wr_ptr <= old_idx;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cheby_fir_tdm.sv
// tb_cheby_fir_tdm: vector tables, corner sequences and random samples vs a sum-of-products model.
// Drives the default N=8, NCH=2, DW=CW=16, FRAC=15 configuration.
module tb_cheby_fir_tdm;

    localparam int N    = 8;
    localparam int NCH  = 2;
    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int FRAC = 15;
    localparam int L    = NCH * N + 4;

    logic              clk;
    logic              rst;
    logic              donext;
    logic [NCH*DW-1:0] xin;
    logic              coef_we;
    logic [2:0]        coef_addr;
    logic [CW-1:0]     coef_data;
    logic              busy;
    logic              yvalid;
    logic [NCH*DW-1:0] yout;
    logic [NCH*DW-1:0] xin_d;
    logic [NCH-1:0]    sat;
    logic              overrun;

    cheby_fir_tdm dut (
        .clk30x    (clk),
        .rst       (rst),
        .donext    (donext),
        .xin       (xin),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .busy      (busy),
        .yvalid    (yvalid),
        .yout      (yout),
        .xin_d     (xin_d),
        .sat       (sat),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int errors = 0;
    int checks = 0;

    // Reference: per-channel sample history (newest first) and the tap weights.
    longint            hist [NCH][N];
    longint            hm [N];
    logic [DW-1:0]     exp_y [NCH];
    logic [DW-1:0]     exp_xd [NCH];
    logic [NCH-1:0]    exp_sat;
    logic [NCH*DW-1:0] got_y;
    logic [NCH*DW-1:0] got_xd;
    logic [NCH-1:0]    got_sat;

    typedef struct {
        logic [NCH*DW-1:0] x;
        logic [NCH*DW-1:0] y;
        logic [NCH*DW-1:0] xd;
        logic [NCH-1:0]    s;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, expv);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < N; k++)
                hist[c][k] = 0;
        for (int k = 0; k < N; k++)
            hm[k] = (k == 0) ? 32767 : 0;
    endfunction

    function automatic void model_step(input logic [NCH*DW-1:0] xv);
        longint acc;
        longint v;
        for (int c = 0; c < NCH; c++) begin
            for (int k = N - 1; k > 0; k--)
                hist[c][k] = hist[c][k-1];
            hist[c][0] = longint'($signed(xv[c*DW +: DW]));
            acc = 0;
            for (int k = 0; k < N; k++)
                acc += hist[c][k] * hm[k];
            v = (acc + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
            exp_sat[c] = 1'b0;
            if (v > 32767) begin
                v = 32767;
                exp_sat[c] = 1'b1;
            end else if (v < -32768) begin
                v = -32768;
                exp_sat[c] = 1'b1;
            end
            exp_y[c]  = 16'(v);
            exp_xd[c] = 16'(hist[c][N-1]);
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        donext  = 1'b0;
        coef_we = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic write_coef(input logic [2:0] a, input logic [CW-1:0] d);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        hm[a] = longint'($signed(d));
    endtask

    task automatic cmp_out(input string tag);
        got_y   = yout;
        got_xd  = xin_d;
        got_sat = sat;
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("%s y%0d", tag, c), got_y[c*DW +: DW], exp_y[c]);
            chk($sformatf("%s xd%0d", tag, c), got_xd[c*DW +: DW], exp_xd[c]);
            chk($sformatf("%s sat%0d", tag, c), got_sat[c], exp_sat[c]);
        end
    endtask

    task automatic wait_yvalid(input int start, input string tag);
        int lat;
        lat = 0;
        for (int k = start; k <= L + 10; k++) begin
            @(posedge clk);
            #1;
            if (yvalid) begin
                lat = k;
                break;
            end
        end
        chk({tag, " latency"}, lat, L);
        if (lat != 0) cmp_out(tag);
    endtask

    task automatic run_sample(input logic [NCH*DW-1:0] xv, input bit we,
                              input logic [2:0] wa, input logic [CW-1:0] wd,
                              input bit bw, input string tag);
        int lat;
        @(negedge clk);
        donext    = 1'b1;
        xin       = xv;
        coef_we   = we;
        coef_addr = wa;
        coef_data = wd;
        @(posedge clk);
        #1;
        donext  = 1'b0;
        coef_we = 1'b0;
        if (we) hm[wa] = longint'($signed(wd));
        model_step(xv);
        chk({tag, " busy"}, busy, 1'b1);
        lat = 0;
        for (int k = 1; k <= L + 10; k++) begin
            if (bw && k == 3) begin
                @(negedge clk);
                coef_we   = 1'b1;
                coef_addr = 3'd0;
                coef_data = 16'h0000;
            end
            @(posedge clk);
            #1;
            coef_we = 1'b0;
            if (yvalid) begin
                lat = k;
                break;
            end
        end
        chk({tag, " latency"}, lat, L);
        if (lat != 0) begin
            chk({tag, " busy drop"}, busy, 1'b0);
            cmp_out(tag);
            @(posedge clk);
            #1;
            chk({tag, " pulse"}, yvalid, 1'b0);
        end
    endtask

    initial begin
        logic [NCH*DW-1:0] xa;
        bit seen;
        rst       = 1'b1;
        donext    = 1'b0;
        xin       = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        model_reset();

        for (int i = 0; i < 16; i++) begin
            vt[i].x  = '0;
            vt[i].y  = '0;
            vt[i].xd = '0;
            vt[i].s  = '0;
        end
        vt[0].x  = 32'h0000_7FFF;
        vt[0].y  = 32'h0000_4000;
        vt[1].y  = 32'h0000_2000;
        vt[2].y  = 32'h0000_1000;
        vt[7].xd = 32'h0000_7FFF;
        for (int i = 8; i < 16; i++) begin
            vt[i].x = 32'h8000_7FFF;
            vt[i].y = 32'h8000_7FFF;
            vt[i].s = 2'b11;
        end
        vt[8].y   = 32'h8001_7FFE;
        vt[8].s   = 2'b00;
        vt[15].xd = 32'h8000_7FFF;

        // Reset state and identity passthrough.
        do_reset();
        #1;
        chk("reset busy", busy, 1'b0);
        chk("reset yvalid", yvalid, 1'b0);
        chk("reset overrun", overrun, 1'b0);
        chk("reset yout", yout, 32'h0);
        chk("reset xin_d", xin_d, 32'h0);
        chk("reset sat", sat, 2'b00);
        run_sample(32'hFEDC_1234, 1'b0, 3'd0, 16'h0, 1'b0, "ident");
        chk("ident const", got_y, 32'hFEDC_1234);

        // donext during the OUT cycle is lost; the very next cycle is accepted.
        @(negedge clk);
        donext = 1'b1;
        xin    = 32'h0100_0200;
        @(posedge clk);
        #1;
        donext = 1'b0;
        model_step(32'h0100_0200);
        for (int k = 1; k < L; k++) begin
            @(posedge clk);
            #1;
        end
        chk("outcyc pre overrun", overrun, 1'b0);
        @(negedge clk);
        donext = 1'b1;
        xin    = 32'h0300_0400;
        @(posedge clk);
        #1;
        chk("outcyc yvalid", yvalid, 1'b1);
        cmp_out("outcyc first");
        @(posedge clk);
        #1;
        donext = 1'b0;
        chk("outcyc overrun", overrun, 1'b1);
        chk("outcyc accepted", busy, 1'b1);
        model_step(32'h0300_0400);
        wait_yvalid(1, "outcyc second");

        // Overrun 5 cycles into a computation.
        do_reset();
        #1;
        chk("rst clears overrun", overrun, 1'b0);
        @(negedge clk);
        donext = 1'b1;
        xin    = 32'h1111_2222;
        @(posedge clk);
        #1;
        donext = 1'b0;
        model_step(32'h1111_2222);
        repeat (4) @(posedge clk);
        @(negedge clk);
        donext = 1'b1;
        xin    = 32'h7777_6666;
        @(posedge clk);
        #1;
        donext = 1'b0;
        chk("ovr flag", overrun, 1'b1);
        wait_yvalid(6, "ovr");
        do_reset();
        #1;
        chk("ovr cleared", overrun, 1'b0);

        // Impulse and saturation tables.
        for (int i = 0; i < 16; i++) begin
            if (i == 0) begin
                do_reset();
                write_coef(3'd0, 16'h4000);
                write_coef(3'd1, 16'h2000);
                write_coef(3'd2, 16'h1000);
            end
            if (i == 8) begin
                do_reset();
                for (int k = 0; k < N; k++) write_coef(3'(k), 16'h7FFF);
            end
            run_sample(vt[i].x, 1'b0, 3'd0, 16'h0, 1'b0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d tab y", i), got_y, vt[i].y);
            chk($sformatf("vec%0d tab xd", i), got_xd, vt[i].xd);
            chk($sformatf("vec%0d tab sat", i), got_sat, vt[i].s);
        end

        // Reset in the middle of MAC.
        do_reset();
        run_sample(32'h0100_0555, 1'b0, 3'd0, 16'h0, 1'b0, "pre abort");
        @(negedge clk);
        donext = 1'b1;
        xin    = 32'h2222_3333;
        @(posedge clk);
        #1;
        donext = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort busy", busy, 1'b0);
        chk("abort yvalid", yvalid, 1'b0);
        chk("abort yout", yout, 32'h0);
        chk("abort xin_d", xin_d, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (yvalid) seen = 1'b1;
        end
        chk("abort no yvalid", seen, 1'b0);
        run_sample(32'hC000_0042, 1'b0, 3'd0, 16'h0, 1'b0, "post abort");

        // Moving average, ch0 ramp across three buffer wraps, ch1 idle.
        do_reset();
        for (int k = 0; k < N; k++) write_coef(3'(k), 16'h1000);
        for (int i = 1; i <= 24; i++) begin
            xa = {16'h0000, 16'(i)};
            run_sample(xa, 1'b0, 3'd0, 16'h0, 1'b0, $sformatf("ramp%0d", i));
        end

        // Random coefficients and samples, with same-cycle and busy coef writes.
        do_reset();
        for (int k = 0; k < N; k++) write_coef(3'(k), 16'($urandom_range(0, 16'hFFFF)));
        for (int i = 0; i < 40; i++) begin
            xa = (i % 7 == 0) ? 32'h8000_7FFF : 32'($urandom);
            run_sample(xa, ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
                       16'($urandom_range(0, 16'hFFFF)), (i % 5 == 2),
                       $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
